// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with timeout and bounded retry,
// debounces lock, then releases downstream domain resets one at a time in ascending order.
module pll_lock_supervisor #(
  parameter int unsigned NUM_CH           = 3,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned STAGGER_CYC      = 256,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned CNT_W            = 17
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pll_lock,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] rst_ch_n,
  output logic              all_ready,
  output logic              fail,
  output logic [3:0]        retry_cnt
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] StaggerLast = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IdxLast     = IDX_W'(NUM_CH - 1);
  localparam logic [3:0]       RetryMax    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelease,
    StRun,
    StFail
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [IDX_W-1:0] idx_q;
  logic             lock_meta_q;
  logic             lock_s_q;
  logic             lock_lost;

  // pll_lock is asynchronous to sys_clk; its 2-cycle latency is part of the debounce window.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Saturating increment: the only wrap is the explicit one in StRelease.
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign lock_lost = ((state_q == StRelease) || (state_q == StRun)) && !lock_s_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      idx_q     <= '0;
      pll_rst   <= 1'b1;
      rst_ch_n  <= '0;
      all_ready <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else if (relock_req || lock_lost) begin
      // A forced relock and a lock loss once channels are live both restart from scratch.
      state_q   <= StPllRst;
      cnt_q     <= '0;
      idx_q     <= '0;
      pll_rst   <= 1'b1;
      rst_ch_n  <= '0;
      all_ready <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == RstLast) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StWaitLock: begin
          if (lock_s_q) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_q   <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt < RetryMax) begin
              state_q   <= StPllRst;
              retry_cnt <= retry_cnt + 4'd1;
            end else begin
              state_q <= StFail;
              fail    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StStable: begin
          if (!lock_s_q) begin
            // Any dropout demands a fresh run of consecutive lock cycles and a fresh timeout.
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StRelease: begin
          if (cnt_q == StaggerLast) begin
            cnt_q <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (idx_q == IDX_W'(k)) begin
                rst_ch_n[k] <= 1'b1;
              end
            end
            if (idx_q == IdxLast) begin
              state_q   <= StRun;
              all_ready <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StRun: begin
          state_q <= StRun;
        end

        StFail: begin
          pll_rst  <= 1'b1;
          rst_ch_n <= '0;
          fail     <= 1'b1;
        end

        default: begin
          state_q   <= StPllRst;
          cnt_q     <= '0;
          idx_q     <= '0;
          pll_rst   <= 1'b1;
          rst_ch_n  <= '0;
          all_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises a PLL from the free-running board clock: pulses the PLL reset, waits for lock with a timeout, and retries a bounded number of times.
- Debounces lock, then releases NUM_CH per-domain resets in a staggered, ascending order.
- On loss of lock it re-asserts every domain reset and restarts the sequence.
- Sits between the PLL wrapper (drives its RST, consumes its lock) and all downstream clock-domain reset synchronisers.

Parameters:
- NUM_CH, 3, number of downstream reset channels (1..16).
- PLL_RST_CYC, 16, sys_clk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT_CYC, 65536, cycles allowed in WAIT_LOCK before the attempt is declared failed.
- LOCK_STABLE_CYC, 1024, consecutive synchronised-lock-high cycles required before release.
- STAGGER_CYC, 256, cycles between successive channel releases (>=1).
- MAX_RETRY, 3, re-attempts after the first timeout before FAIL (0..15).
- CNT_W, 17, shared counter width; must hold the largest of the cycle parameters minus 1.

Ports:
- sys_clk  in  1  free-running reference clock, not from the PLL.
- sys_rst_n  in  1  synchronous, active-low reset.
- pll_lock  in  1  PLL lock, asynchronous to sys_clk.
- relock_req  in  1  single-cycle request to force a full relock.
- pll_rst  out  1  active-high PLL reset.
- rst_ch_n  out  NUM_CH  per-channel active-low resets; bit k released k-th.
- all_ready  out  1  high while every channel is released (RUN).
- fail  out  1  sticky; retries exhausted.
- retry_cnt  out  4  timeouts in the current attempt sequence.

Behaviour:
- One clock, sys_clk. Reset is synchronous and active-low on sys_rst_n. All outputs are registered.
- Reset values: state=PLLRST, pll_rst=1, rst_ch_n=all 0, all_ready=0, fail=0, retry_cnt=0, counter=0, channel index=0.
- pll_lock passes through a 2-flop synchroniser to form lock_s; latency is 2 cycles and counts inside the debounce.
- Priority, highest first: sys_rst_n, relock_req, loss of lock_s, counter events.

State machine:
- PLLRST: pll_rst=1 and all channels held in reset. After PLL_RST_CYC cycles go to WAIT_LOCK with counter=0; pll_rst drops on that edge.
- WAIT_LOCK: pll_rst=0. If lock_s=1, go to STABLE with counter=0.
  - On counter==LOCK_TIMEOUT_CYC-1 with lock_s=0 and retry_cnt<MAX_RETRY: retry_cnt+1, go to PLLRST.
  - On the same condition with retry_cnt==MAX_RETRY: go to FAIL.
- STABLE: counts consecutive lock_s=1 cycles.
  - lock_s=0: go to WAIT_LOCK with counter=0 (fresh timeout window); retry_cnt unchanged.
  - counter==LOCK_STABLE_CYC-1: go to RELEASE with counter=0 and index=0.
- RELEASE: each time counter==STAGGER_CYC-1, set rst_ch_n[index]=1, increment index and wrap the counter. Channel k releases (k+1)*STAGGER_CYC cycles after entry.
  - When the last channel is released, go to RUN; all_ready=1 from the same edge that sets rst_ch_n[NUM_CH-1].
- RUN: holds. On lock_s=0: on the next edge rst_ch_n=all 0, all_ready=0, retry_cnt=0, go to PLLRST.
  - Lock loss during RELEASE behaves identically; already-released channels re-assert together.
- FAIL: fail=1, pll_rst=1, rst_ch_n=all 0. Exits only via sys_rst_n or relock_req.
- relock_req=1 in any state: next edge goes to PLLRST with retry_cnt=0, fail=0, rst_ch_n=all 0, all_ready=0, counter=0.
- relock_req while already in PLLRST restarts the PLL_RST_CYC count.
- Counter saturation: never wraps except the defined RELEASE wrap.
- retry_cnt never exceeds MAX_RETRY.

Test Plan:
Bench parameters: NUM_CH=3, PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, STAGGER_CYC=4, MAX_RETRY=2.
- Clean lock: sys_rst_n released, pll_lock high from cycle 6.
  - pll_rst high for exactly 4 cycles after reset.
  - rst_ch_n goes 001, 011, 111 at 4-cycle spacing, all_ready=1 with 111, retry_cnt=0.
- Timeout and retry: pll_lock held 0.
  - Three pll_rst pulses of 4 cycles, spaced 32+4 cycles apart; retry_cnt steps 0→1→2.
  - Then fail=1, pll_rst=1, rst_ch_n=000. Holding pll_lock=1 afterwards changes nothing.
  - relock_req pulse clears fail and retry_cnt and restarts the sequence.
- Lock glitch: pll_lock drops for 1 cycle at STABLE count 5.
  - Returns to WAIT_LOCK and requires a fresh 8 consecutive cycles.
  - First release lands 8+4 cycles after lock_s re-rises; no extra pll_rst pulse.
- Loss in RUN: drop pll_lock for 3 cycles while all_ready=1.
  - rst_ch_n=000 and all_ready=0 exactly 3 cycles after pll_lock falls (2 synchroniser cycles + 1 register).
  - pll_rst pulses for 4 cycles, retry_cnt=0, full re-sequence.
- Loss mid-RELEASE: drop lock when rst_ch_n=001.
  - All channels re-assert together (rst_ch_n=000) and the sequence enters PLLRST.
- Reset priority: sys_rst_n=0 in RUN asserted in the same cycle as relock_req.
  - All outputs at reset values on the next edge; sequence restarts normally after sys_rst_n releases.
